// File: rtl/puzzle_stage_fsm.sv
`timescale 1ns/1ps
// Purpose : stage progression controller for the puzzle map (trigger tiles, redraw handshake, goal detect).
// Latency : stage/redraw_req/stage_changed/finished update on the clock edge after the qualifying input cycle.
// Backpressure: no stage change is taken while a redraw is outstanding; the drawer releases it with done_redraw.
// Optional build macro MOVE_COUNTER_EN adds a saturating 16-bit count of stage-changing activations.
module puzzle_stage_fsm #(
    parameter int NUM_STAGES = 4,
    parameter int X_W        = 9,
    parameter int Y_W        = 8,
    parameter int HIT_TOL    = 2,
    parameter int SW         = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      activate,
    input  logic                      sprite_dead,
    input  logic                      done_redraw,
    input  logic [X_W-1:0]            char_x,
    input  logic [Y_W-1:0]            char_y,
    input  logic [NUM_STAGES*X_W-1:0] fwd_x,
    input  logic [NUM_STAGES*Y_W-1:0] fwd_y,
    input  logic [NUM_STAGES*X_W-1:0] back_x,
    input  logic [NUM_STAGES*Y_W-1:0] back_y,
    input  logic [X_W-1:0]            goal_x,
    input  logic [Y_W-1:0]            goal_y,
    output logic [SW-1:0]             stage,
    output logic                      redraw_req,
    output logic                      stage_changed,
    output logic                      finished,
    output logic [15:0]               move_count
);

    typedef enum logic [1:0] {
        REDRAW = 2'd0,
        PLAY   = 2'd1,
        DONE   = 2'd2
    } state_t;

    localparam logic [SW-1:0]  LAST  = SW'(NUM_STAGES - 1);
    localparam logic [X_W:0]   TOL_X = (X_W + 1)'(HIT_TOL);
    localparam logic [Y_W:0]   TOL_Y = (Y_W + 1)'(HIT_TOL);

    state_t state;
    logic   armed;

    logic [X_W-1:0] fwd_tx;
    logic [Y_W-1:0] fwd_ty;
    logic [X_W-1:0] back_tx;
    logic [Y_W-1:0] back_ty;
    logic           fwd_hit;
    logic           back_hit;
    logic           goal_hit;
    logic           accept;

    // Absolute distance one bit wider than the coordinate, so 0 vs max never wraps into a match.
    function automatic logic near_x(input logic [X_W-1:0] a, input logic [X_W-1:0] b);
        logic [X_W:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, b} - {1'b0, a};
        return (d <= TOL_X);
    endfunction

    function automatic logic near_y(input logic [Y_W-1:0] a, input logic [Y_W-1:0] b);
        logic [Y_W:0] d;
        if (a >= b) d = {1'b0, a} - {1'b0, b};
        else        d = {1'b0, b} - {1'b0, a};
        return (d <= TOL_Y);
    endfunction

    // Select the current stage's trigger tiles and evaluate every tile match for this cycle.
    always_comb begin
        fwd_tx   = fwd_x[int'(stage) * X_W +: X_W];
        fwd_ty   = fwd_y[int'(stage) * Y_W +: Y_W];
        back_tx  = back_x[int'(stage) * X_W +: X_W];
        back_ty  = back_y[int'(stage) * Y_W +: Y_W];
        fwd_hit  = (stage != LAST) && near_x(char_x, fwd_tx) && near_y(char_y, fwd_ty);
        back_hit = (stage != '0) && near_x(char_x, back_tx) && near_y(char_y, back_ty);
        goal_hit = (stage == LAST) && near_x(char_x, goal_x) && near_y(char_y, goal_y);
        accept   = (state == PLAY) && activate && armed;
    end

    // Stage FSM: redraw handshake, death restart, goal completion and debounced trigger moves.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= REDRAW;
            stage         <= '0;
            redraw_req    <= 1'b1;
            stage_changed <= 1'b0;
            finished      <= 1'b0;
            armed         <= 1'b0;
        end else begin
            case (state)
                REDRAW: begin
                    stage_changed <= 1'b0;
                    armed         <= 1'b0;
                    redraw_req    <= 1'b1;
                    if (done_redraw) begin
                        state      <= PLAY;
                        redraw_req <= 1'b0;
                    end
                end
                PLAY: begin
                    stage_changed <= 1'b0;
                    if (sprite_dead) begin
                        stage         <= '0;
                        state         <= REDRAW;
                        redraw_req    <= 1'b1;
                        armed         <= 1'b0;
                        stage_changed <= (stage != '0);
                    end else if (goal_hit) begin
                        state    <= DONE;
                        finished <= 1'b1;
                    end else if (accept) begin
                        armed <= 1'b0;
                        if (fwd_hit) begin
                            stage         <= stage + 1'b1;
                            state         <= REDRAW;
                            redraw_req    <= 1'b1;
                            stage_changed <= 1'b1;
                        end else if (back_hit) begin
                            stage         <= stage - 1'b1;
                            state         <= REDRAW;
                            redraw_req    <= 1'b1;
                            stage_changed <= 1'b1;
                        end
                    end else if (!activate) begin
                        armed <= 1'b1;
                    end
                end
                DONE: begin
                    // Terminal: every output holds until reset.
                end
                default: begin
                    state      <= REDRAW;
                    stage      <= '0;
                    redraw_req <= 1'b1;
                    armed      <= 1'b0;
                end
            endcase
        end
    end

`ifdef MOVE_COUNTER_EN
    logic        move_ok;
    logic [15:0] move_cnt;

    assign move_ok = accept && !sprite_dead && !goal_hit && (fwd_hit || back_hit);

    // Saturating count of activations that actually moved the stage; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            move_cnt <= 16'h0000;
        end else if (move_ok && (move_cnt != 16'hFFFF)) begin
            move_cnt <= move_cnt + 16'h0001;
        end
    end

    assign move_count = move_cnt;
`else
    assign move_count = 16'h0000;
`endif

endmodule

// File: tb/tb_puzzle_stage_fsm.sv
`timescale 1ns/1ps
// Bench for puzzle_stage_fsm: directed vector table, hand sequences, then random traffic vs a behavioural model.
module tb_puzzle_stage_fsm;

    localparam int N   = 4;
    localparam int XW  = 9;
    localparam int YW  = 8;
    localparam int TOL = 2;
    localparam int SWB = 2;

    localparam int PH_DRAW = 0;
    localparam int PH_PLAY = 1;
    localparam int PH_END  = 2;

    logic            clock = 1'b0;
    logic            reset;
    logic            activate;
    logic            sprite_dead;
    logic            done_redraw;
    logic [XW-1:0]   char_x;
    logic [YW-1:0]   char_y;
    logic [N*XW-1:0] fwd_x;
    logic [N*YW-1:0] fwd_y;
    logic [N*XW-1:0] back_x;
    logic [N*YW-1:0] back_y;
    logic [XW-1:0]   goal_x;
    logic [YW-1:0]   goal_y;
    logic [SWB-1:0]  stage;
    logic            redraw_req;
    logic            stage_changed;
    logic            finished;
    logic [15:0]     move_count;

    // Tile map: fwd1 and back1 coincide at (0,20) so stage 1 exercises forward-over-backward priority.
    int fx[N] = '{100, 0, 300, 0};
    int fy[N] = '{50, 20, 70, 0};
    int bx[N] = '{0, 0, 40, 250};
    int by[N] = '{0, 20, 40, 100};
    int gx = 400;
    int gy = 200;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state.
    int m_stage;
    int m_phase;
    bit m_ready;
    bit m_chg;
    int m_moves;

    typedef struct {
        bit act;
        bit dead;
        bit dr;
        int x;
        int y;
        int st;
        bit rq;
        bit ch;
        bit fn;
    } vec_t;

    vec_t tbl[$];

    puzzle_stage_fsm #(
        .NUM_STAGES(N), .X_W(XW), .Y_W(YW), .HIT_TOL(TOL)
    ) dut (
        .clock(clock), .reset(reset), .activate(activate), .sprite_dead(sprite_dead),
        .done_redraw(done_redraw), .char_x(char_x), .char_y(char_y),
        .fwd_x(fwd_x), .fwd_y(fwd_y), .back_x(back_x), .back_y(back_y),
        .goal_x(goal_x), .goal_y(goal_y), .stage(stage), .redraw_req(redraw_req),
        .stage_changed(stage_changed), .finished(finished), .move_count(move_count)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(bit a, bit d, bit r, int x, int y, int st, bit rq, bit ch, bit fn);
        vec_t v;
        v.act = a; v.dead = d; v.dr = r; v.x = x; v.y = y;
        v.st = st; v.rq = rq; v.ch = ch; v.fn = fn;
        return v;
    endfunction

    function automatic bit near(int a, int b);
        int d;
        d = a - b;
        if (d < 0) d = -d;
        return d <= TOL;
    endfunction

    function automatic int exp_mc();
`ifdef MOVE_COUNTER_EN
        return (m_moves > 65535) ? 65535 : m_moves;
`else
        return 0;
`endif
    endfunction

    task automatic chk(string nm, int got, int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_update();
        int cx;
        int cy;
        cx = int'(char_x);
        cy = int'(char_y);
        if (reset) begin
            m_stage = 0; m_phase = PH_DRAW; m_ready = 0; m_chg = 0; m_moves = 0;
            return;
        end
        m_chg = 0;
        if (m_phase == PH_DRAW) begin
            if (done_redraw) m_phase = PH_PLAY;
        end else if (m_phase == PH_PLAY) begin
            if (sprite_dead) begin
                m_chg   = (m_stage != 0);
                m_stage = 0;
                m_phase = PH_DRAW;
                m_ready = 0;
            end else if (m_stage == N - 1 && near(cx, gx) && near(cy, gy)) begin
                m_phase = PH_END;
            end else if (activate && m_ready) begin
                m_ready = 0;
                if (m_stage < N - 1 && near(cx, fx[m_stage]) && near(cy, fy[m_stage])) begin
                    m_stage++; m_phase = PH_DRAW; m_chg = 1; m_moves++;
                end else if (m_stage > 0 && near(cx, bx[m_stage]) && near(cy, by[m_stage])) begin
                    m_stage--; m_phase = PH_DRAW; m_chg = 1; m_moves++;
                end
            end else if (!activate) begin
                m_ready = 1;
            end
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        chk("model_stage", int'(stage), m_stage);
        chk("model_redraw_req", int'(redraw_req), int'(m_phase == PH_DRAW));
        chk("model_stage_changed", int'(stage_changed), int'(m_chg));
        chk("model_finished", int'(finished), int'(m_phase == PH_END));
        chk("model_move_count", int'(move_count), exp_mc());
    endtask

    task automatic drive(bit a, bit d, bit r, int x, int y);
        activate    = a;
        sprite_dead = d;
        done_redraw = r;
        char_x      = x[XW-1:0];
        char_y      = y[YW-1:0];
    endtask

    task automatic exp_out(string nm, int st, bit rq, bit ch, bit fn);
        chk({nm, "_stage"}, int'(stage), st);
        chk({nm, "_redraw_req"}, int'(redraw_req), int'(rq));
        chk({nm, "_stage_changed"}, int'(stage_changed), int'(ch));
        chk({nm, "_finished"}, int'(finished), int'(fn));
    endtask

    initial begin
        int mc_exp;
        for (int s = 0; s < N; s++) begin
            fwd_x[s*XW +: XW]  = XW'(fx[s]);
            fwd_y[s*YW +: YW]  = YW'(fy[s]);
            back_x[s*XW +: XW] = XW'(bx[s]);
            back_y[s*YW +: YW] = YW'(by[s]);
        end
        goal_x = XW'(gx);
        goal_y = YW'(gy);

        // act, dead, done_redraw, x, y  ->  stage, redraw_req, stage_changed, finished
        tbl.push_back(mk(0,0,0, 200,150, 0,1,0,0));
        tbl.push_back(mk(0,0,0, 200,150, 0,1,0,0));
        tbl.push_back(mk(0,0,0, 200,150, 0,1,0,0));
        tbl.push_back(mk(0,0,0, 200,150, 0,1,0,0));
        tbl.push_back(mk(0,0,1, 200,150, 0,0,0,0));   // 4: redraw done -> play
        tbl.push_back(mk(0,0,0, 101,49,  0,0,0,0));   // arm
        tbl.push_back(mk(1,0,0, 101,49,  1,1,1,0));   // 6: fwd0 within tolerance
        tbl.push_back(mk(1,0,0, 101,49,  1,1,0,0));
        tbl.push_back(mk(1,0,1, 101,49,  1,0,0,0));   // key held through redraw
        tbl.push_back(mk(1,0,0, 101,49,  1,0,0,0));
        tbl.push_back(mk(1,0,0, 2,20,    1,0,0,0));   // 10: on fwd1 but not re-armed
        tbl.push_back(mk(0,0,0, 101,49,  1,0,0,0));
        tbl.push_back(mk(1,0,0, 511,20,  1,0,0,0));   // 12: no wrap match against x=0
        tbl.push_back(mk(0,0,0, 2,20,    1,0,0,0));
        tbl.push_back(mk(1,0,0, 2,20,    2,1,1,0));   // 14: fwd and back both hit, forward wins
        tbl.push_back(mk(0,0,1, 2,20,    2,0,0,0));
        tbl.push_back(mk(0,0,0, 40,43,   2,0,0,0));
        tbl.push_back(mk(1,0,0, 40,43,   2,0,0,0));   // 17: back2 off by 3
        tbl.push_back(mk(0,0,0, 40,42,   2,0,0,0));
        tbl.push_back(mk(1,0,0, 40,42,   1,1,1,0));   // 19: back2 at tolerance edge
        tbl.push_back(mk(0,0,1, 40,42,   1,0,0,0));
        tbl.push_back(mk(0,0,0, 2,20,    1,0,0,0));
        tbl.push_back(mk(1,0,0, 2,20,    2,1,1,0));   // 22
        tbl.push_back(mk(0,0,1, 200,150, 2,0,0,0));
        tbl.push_back(mk(0,0,0, 300,70,  2,0,0,0));
        tbl.push_back(mk(1,1,0, 300,70,  0,1,1,0));   // 25: death beats a valid move
        tbl.push_back(mk(0,1,0, 300,70,  0,1,0,0));   // death ignored in redraw
        tbl.push_back(mk(0,0,1, 200,150, 0,0,0,0));
        tbl.push_back(mk(0,0,0, 100,50,  0,0,0,0));
        tbl.push_back(mk(1,0,0, 100,50,  1,1,1,0));
        tbl.push_back(mk(0,0,1, 0,20,    1,0,0,0));
        tbl.push_back(mk(0,0,0, 0,20,    1,0,0,0));
        tbl.push_back(mk(1,0,0, 0,20,    2,1,1,0));
        tbl.push_back(mk(0,0,1, 300,70,  2,0,0,0));
        tbl.push_back(mk(0,0,0, 300,70,  2,0,0,0));
        tbl.push_back(mk(1,0,0, 300,70,  3,1,1,0));   // 35: reach last stage
        tbl.push_back(mk(0,0,1, 200,150, 3,0,0,0));
        tbl.push_back(mk(0,0,0, 402,198, 3,0,0,1));   // 37: goal without activate
        tbl.push_back(mk(1,0,0, 402,198, 3,0,0,1));
        tbl.push_back(mk(1,1,1, 402,198, 3,0,0,1));   // done holds
        tbl.push_back(mk(0,0,0, 200,150, 3,0,0,1));

        reset = 1'b1;
        drive(0, 0, 0, 200, 150);
        step();
        step();
        exp_out("reset", 0, 1, 0, 0);
        chk("reset_move_count", int'(move_count), 0);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].act, tbl[i].dead, tbl[i].dr, tbl[i].x, tbl[i].y);
            step();
            exp_out($sformatf("vec%0d", i), tbl[i].st, tbl[i].rq, tbl[i].ch, tbl[i].fn);
            if (i == 22) begin
`ifdef MOVE_COUNTER_EN
                mc_exp = 4;
`else
                mc_exp = 0;
`endif
                chk("move_count_after_4_moves", int'(move_count), mc_exp);
            end
        end

        // Reset leaves DONE; goal outside the last stage and stray done_redraw do nothing.
        reset = 1'b1;
        drive(0, 0, 0, 200, 150);
        step();
        exp_out("rst_from_done", 0, 1, 0, 0);
        reset = 1'b0;
        drive(0, 0, 1, 200, 150);
        step();
        exp_out("seq_play", 0, 0, 0, 0);
        drive(0, 0, 1, 400, 200);
        step();
        exp_out("seq_goal_stage0", 0, 0, 0, 0);
        drive(1, 0, 0, 100, 50);
        step();
        exp_out("seq_fwd", 1, 1, 1, 0);
        reset = 1'b1;
        drive(0, 0, 0, 200, 150);
        step();
        exp_out("rst_mid_redraw", 0, 1, 0, 0);
        reset = 1'b0;
        step();
        exp_out("seq_wait_redraw", 0, 1, 0, 0);

        // Random traffic, aimed mostly at the tiles that matter for the model's current stage.
        for (int c = 0; c < 4000; c++) begin
            int sel;
            int tx;
            int ty;
            sel = int'($urandom_range(0, 99));
            if (sel < 45 && m_stage < N - 1) begin
                tx = fx[m_stage]; ty = fy[m_stage];
            end else if (sel < 70 && m_stage > 0) begin
                tx = bx[m_stage]; ty = by[m_stage];
            end else if (sel < 85) begin
                tx = gx; ty = gy;
            end else begin
                tx = int'($urandom_range(0, 511)); ty = int'($urandom_range(0, 255));
            end
            tx = (tx + int'($urandom_range(0, 6)) - 3 + 512) % 512;
            ty = (ty + int'($urandom_range(0, 6)) - 3 + 256) % 256;
            reset = ($urandom_range(0, 299) == 0);
            drive(1'($urandom_range(0, 1)), ($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0), tx, ty);
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/puzzle_stage_fsm.md
Name: puzzle_stage_fsm

Overview:
Parametrised level-progression controller for the puzzle map. It tracks which of NUM_STAGES map configurations (bridges, pillar, ...) is active and moves forward or back when the character stands on a per-stage trigger tile and presses activate. Every stage change runs a redraw handshake with the background drawer. The block flags completion when the character reaches the goal tile in the last stage. It sits between the sprite/input logic and the map drawer, and replaces the fixed per-map state machine.

Parameters:
NUM_STAGES, 4, number of map configurations (>=1); stages are 0..NUM_STAGES-1.
X_W, 9, character X coordinate width.
Y_W, 8, character Y coordinate width.
HIT_TOL, 2, per-axis pixel tolerance for a tile match.
SW, $clog2(NUM_STAGES) (minimum 1), stage index width (derived).

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
activate  in  1  player action key, level
sprite_dead  in  1  character died
done_redraw  in  1  one-cycle pulse from drawer: requested redraw complete
char_x  in  X_W  character X
char_y  in  Y_W  character Y
fwd_x  in  NUM_STAGES*X_W  forward trigger X, slice s belongs to stage s
fwd_y  in  NUM_STAGES*Y_W  forward trigger Y
back_x  in  NUM_STAGES*X_W  backward trigger X (slice 0 unused)
back_y  in  NUM_STAGES*Y_W  backward trigger Y (slice 0 unused)
goal_x  in  X_W  goal tile X
goal_y  in  Y_W  goal tile Y
stage  out  SW  current stage index
redraw_req  out  1  high while a redraw of stage is outstanding
stage_changed  out  1  one-cycle pulse when stage updates
finished  out  1  game complete
move_count  out  16  accepted activations (only with MOVE_COUNTER_EN)

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high. All outputs are registered.
- Reset values: state=REDRAW, stage=0, redraw_req=1, stage_changed=0, finished=0, armed=0, move_count=0.
- Tile match: |char_x - tx| <= HIT_TOL and |char_y - ty| <= HIT_TOL.
  - Differences are computed unsigned at W+1 bits, with no wrap, so tile 0 with char_x=511 does not match.
- FSM states: REDRAW, PLAY, DONE.
- REDRAW:
  - redraw_req=1.
  - On done_redraw: next cycle state=PLAY, redraw_req=0.
  - sprite_dead and activate are ignored in this state.
- done_redraw outside REDRAW is ignored.
- Arming (debounce):
  - armed is cleared on every entry to REDRAW.
  - In PLAY, armed is set in any cycle where activate=0.
  - An activation is accepted only when activate=1 and armed=1, and armed is cleared on acceptance. Holding the key never causes back-and-forth stage changes.
- PLAY, priority highest first:
  1. sprite_dead: stage<=0, ->REDRAW. Also pulses stage_changed if stage was non-zero.
  2. stage==NUM_STAGES-1 and goal match (activate not needed): ->DONE, finished<=1.
  3. Accepted activation, stage<NUM_STAGES-1, forward tile s matches: stage<=stage+1, ->REDRAW, stage_changed pulse.
  4. Accepted activation, stage>0, backward tile s matches: stage<=stage-1, ->REDRAW, stage_changed pulse.
  5. Accepted activation with no match: armed cleared, no state change.
- If forward and backward tiles both match, forward wins.
- DONE: all outputs hold; only reset exits.
- NUM_STAGES=1: no forward or backward moves; only the goal check and sprite_dead apply.
- Latency: stage, redraw_req and stage_changed update on the clock edge after the qualifying input cycle.
- Reset mid-redraw: returns to REDRAW of stage 0. The drawer must restart on the redraw_req/stage it sees.

Optional Feature:
- Macro: MOVE_COUNTER_EN.
- Defined: 16-bit move_count increments on each accepted activation that changes stage. It saturates at 16'hFFFF, is cleared by reset, and is not cleared by sprite_dead.
- Undefined: move_count port is tied to 0 and no counter logic is built.

Test Plan:
All scenarios use NUM_STAGES=4 and HIT_TOL=2.
- Reset, then pulse done_redraw at cycle 5 -> redraw_req=1 from reset until 1 cycle after the pulse, then stage=0 in PLAY.
- fwd0=(100,50), char=(101,49), activate raised -> next cycle stage=1, stage_changed=1 for one cycle, redraw_req=1. Activate held through done_redraw -> no further change until activate is released and pressed again.
- Stage 2, back2=(40,40), char=(40,43), activate -> no change (out of tolerance). Char moved to (40,42), activate re-pressed -> stage=1.
- Stage 3, char on goal with activate=0 -> finished=1 next cycle. Later activate and sprite_dead -> no change.
- Stage 2 in PLAY, sprite_dead and matching activate in the same cycle -> stage=0, REDRAW (death wins). sprite_dead during REDRAW -> ignored.
- MOVE_COUNTER_EN: 3 forward moves and 1 backward move -> move_count=4. A no-match activation does not increment.
